// File: rtl/ghost_dir_scheduler_pkg.sv
// Shared types, keycodes and the direction-pick function for the ghost direction scheduler.
package ghost_dir_scheduler_pkg;

  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_D, DIR_U} dir_e;

  localparam logic [7:0] KEY_LEFT  = 8'h1A;
  localparam logic [7:0] KEY_RIGHT = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h16;
  localparam logic [7:0] KEY_HOLD  = 8'h00;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SCAN   = 3'd1;
  localparam logic [2:0] DECIDE = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] NEXT   = 3'd4;

  function automatic logic [7:0] dir2key(input dir_e d);
    case (d)
      DIR_L:   return KEY_LEFT;
      DIR_R:   return KEY_RIGHT;
      DIR_D:   return KEY_DOWN;
      default: return KEY_UP;
    endcase
  endfunction

  function automatic dir_e key2dir(input logic [7:0] k);
    case (k)
      KEY_RIGHT: return DIR_R;
      KEY_DOWN:  return DIR_D;
      KEY_UP:    return DIR_U;
      default:   return DIR_L;
    endcase
  endfunction

  function automatic logic is_dir_key(input logic [7:0] k);
    return (k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_DOWN) || (k == KEY_UP);
  endfunction

  function automatic dir_e opposite(input dir_e d);
    case (d)
      DIR_L:   return DIR_R;
      DIR_R:   return DIR_L;
      DIR_D:   return DIR_U;
      default: return DIR_D;
    endcase
  endfunction

  // legal bit order is {U,D,R,L} = [3:0]; HOLD never contributes a reverse.
  function automatic logic [7:0] pick_dir(input logic [3:0] legal, input logic [7:0] cur,
                                          input logic [5:0] rnd, input int keep);
    logic [3:0] rev, cand;
    logic [1:0] p;
    logic       hit;
    logic [7:0] key;
    key = cur;
    rev = '0;
    hit = 1'b0;
    if (is_dir_key(cur)) rev[opposite(key2dir(cur))] = 1'b1;
    cand = legal & ~rev;
    if (cand == '0) cand = legal;
    if (legal != '0) begin
      if (is_dir_key(cur) && cand[key2dir(cur)] && (int'(rnd[3:0]) < keep)) begin
        key = cur;
      end else begin
        for (int i = 0; i < 4; i++) begin
          p = rnd[5:4] + 2'(i);
          if (!hit && cand[p]) begin
            key = dir2key(dir_e'(p));
            hit = 1'b1;
          end
        end
      end
    end
    return key;
  endfunction

endpackage

// File: rtl/ghost_dir_scheduler_if.sv
// Control/status bundle between the scheduler, the maze wall lookup and the ghost movers.
interface ghost_dir_scheduler_if #(parameter int NUM_GHOSTS = 4);
  logic                    restart;
  logic                    frame_tick;
  logic                    sec;
  logic [NUM_GHOSTS-1:0]   wall_l;
  logic [NUM_GHOSTS-1:0]   wall_r;
  logic [NUM_GHOSTS-1:0]   wall_b;
  logic [NUM_GHOSTS-1:0]   wall_t;
  logic [NUM_GHOSTS*8-1:0] ghost_keycodes;
  logic [NUM_GHOSTS-1:0]   released;
  logic                    busy;
  logic                    overrun;

  modport master (
    output restart, frame_tick, sec, wall_l, wall_r, wall_b, wall_t,
    input  ghost_keycodes, released, busy, overrun
  );

  modport slave (
    input  restart, frame_tick, sec, wall_l, wall_r, wall_b, wall_t,
    output ghost_keycodes, released, busy, overrun
  );
endinterface

// File: rtl/ghost_dir_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, shared by every ghost decision.
module lfsr16 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);
  logic [15:0] q_q;
  logic        fb;

  assign fb = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];

  always_ff @(posedge Clk) begin
    if (Reset) q_q <= seed_i;
    else       q_q <= {fb, q_q[15:1]};
  end

  assign q_o = q_q;
endmodule

// File: rtl/ghost_dir_scheduler.sv
// Per-frame ghost direction scheduler: visits each ghost once per frame_tick and releases
// ghosts from the house on a seconds schedule.
module ghost_dir_scheduler
  import ghost_dir_scheduler_pkg::*;
#(
  parameter int          NUM_GHOSTS  = 4,
  parameter int          RELEASE_SEC = 3,
  parameter int          KEEP_THRESH = 12,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic            Clk,
  input logic            Reset,
  ghost_dir_scheduler_if.slave bus
);
  localparam int IW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

  logic [2:0]                  state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [NUM_GHOSTS-1:0][3:0]  wall_q, wall_d, wall_snap;
  logic [NUM_GHOSTS-1:0][7:0]  key_q, key_d;
  logic [7:0]                  dec_q, dec_d;
  logic [NUM_GHOSTS-1:0]       rel_q, rel_d, rel_hit;
  logic [7:0]                  sec_cnt_q, sec_cnt_d;
  logic [15:0]                 lfsr_q;
  logic                        busy, last;
  logic                        unused_lfsr;

  lfsr16 u_lfsr (.Clk(Clk), .Reset(Reset), .seed_i(LFSR_SEED), .q_o(lfsr_q));

  assign unused_lfsr = ^lfsr_q[15:6];

  // sec is counted regardless of scan state; restart clears the count outright.
  assign sec_cnt_d = bus.restart ? 8'd0 :
                     (bus.sec && sec_cnt_q != 8'hFF) ? sec_cnt_q + 8'd1 : sec_cnt_q;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_lane
    assign wall_snap[g] = {bus.wall_t[g], bus.wall_b[g], bus.wall_r[g], bus.wall_l[g]};
    assign rel_hit[g]   = int'(sec_cnt_d) >= RELEASE_SEC * g;
  end

  assign last = (idx_q == IW'(NUM_GHOSTS - 1));
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wall_d  = wall_q;
    key_d   = key_q;
    dec_d   = dec_q;
    rel_d   = bus.restart ? NUM_GHOSTS'(1) : (rel_q | rel_hit);
    case (state_q)
      IDLE: begin
        if (bus.frame_tick) begin
          state_d = SCAN;
          idx_d   = '0;
          wall_d  = wall_snap;
        end
      end
      SCAN: begin
        if (rel_q[idx_q]) begin
          state_d = DECIDE;
        end else begin
          key_d[idx_q] = KEY_HOLD;
          state_d      = NEXT;
        end
      end
      DECIDE: begin
        dec_d   = pick_dir(~wall_q[idx_q], key_q[idx_q], lfsr_q[5:0], KEEP_THRESH);
        state_d = WRITE;
      end
      // WRITE also advances the index so a released ghost costs three cycles.
      WRITE, NEXT: begin
        if (state_q == WRITE) key_d[idx_q] = dec_q;
        if (last) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.restart) begin
      state_d = IDLE;
      idx_d   = '0;
      key_d   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wall_q    <= '0;
      key_q     <= '0;
      dec_q     <= KEY_HOLD;
      rel_q     <= NUM_GHOSTS'(1);
      sec_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wall_q    <= wall_d;
      key_q     <= key_d;
      dec_q     <= dec_d;
      rel_q     <= rel_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign bus.ghost_keycodes = key_q;
  assign bus.released       = rel_q;
  assign bus.busy           = busy;
  assign bus.overrun        = bus.frame_tick & busy & ~bus.restart & ~Reset;
endmodule
